// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: turns UART command bytes into register bus accesses and
// replies with one byte per command.
//   rx_received/rx_byte/rx_error : byte stream from the UART receiver
//   tx_transmit/tx_byte/tx_busy  : reply byte handshake to the UART transmitter
//   bus_*                        : single-cycle strobed register bus
//   err_count                    : saturating count of error events
//   busy                         : high whenever the command FSM is not idle
module uart_cmd_bridge #(
  parameter int unsigned TIMEOUT  = 2500000,
  parameter logic [7:0]  CMD_WR   = 8'h57,
  parameter logic [7:0]  CMD_RD   = 8'h52,
  parameter logic [7:0]  ACK_BYTE = 8'h4B,
  parameter logic [7:0]  NAK_BYTE = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_received,
  input  logic [7:0] rx_byte,
  input  logic       rx_error,
  output logic       tx_transmit,
  output logic [7:0] tx_byte,
  input  logic       tx_busy,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  input  logic       bus_rvalid,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, WAIT_RD, SEND, WAIT_TX_START, WAIT_TX_END
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          is_rd, is_rd_d;
  logic          tx_transmit_d, bus_we_d, bus_re_d, busy_d;
  logic [7:0]    tx_byte_d, bus_addr_d, bus_wdata_d, err_count_d;
  logic          err_event;

  logic op_valid, cnt_hit, rd_ok, rx_stray;
  assign op_valid = (rx_byte == CMD_WR) || (rx_byte == CMD_RD);
  assign cnt_hit  = (cnt == CNT_MAX);
  // bus_re is registered, so it is still high in the first WAIT_RD cycle:
  // an rvalid coinciding with the strobe is rejected here.
  assign rd_ok    = bus_rvalid && !bus_re;
  assign rx_stray = rx_error || rx_received;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:
        if (!rx_error && rx_received) state_d = op_valid ? GET_ADDR : SEND;
      GET_ADDR:
        if (rx_error)         state_d = IDLE;
        else if (rx_received) state_d = is_rd ? BUS_RD : GET_DATA;
        else if (cnt_hit)     state_d = IDLE;
      GET_DATA:
        if (rx_error)         state_d = IDLE;
        else if (rx_received) state_d = BUS_WR;
        else if (cnt_hit)     state_d = IDLE;
      BUS_WR:  state_d = SEND;
      BUS_RD:  state_d = WAIT_RD;
      WAIT_RD:
        if (rd_ok || cnt_hit) state_d = SEND;
      SEND:
        if (!tx_busy) state_d = WAIT_TX_START;
      WAIT_TX_START:
        if (tx_busy)      state_d = WAIT_TX_END;
        else if (cnt_hit) state_d = IDLE;
      WAIT_TX_END:
        if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    is_rd_d       = is_rd;
    tx_byte_d     = tx_byte;
    bus_addr_d    = bus_addr;
    bus_wdata_d   = bus_wdata;
    bus_we_d      = 1'b0;
    bus_re_d      = 1'b0;
    tx_transmit_d = 1'b0;
    err_event     = 1'b0;
    case (state)
      IDLE:
        if (rx_error) begin
          err_event = 1'b1;
        end else if (rx_received) begin
          if (op_valid) begin
            is_rd_d = (rx_byte == CMD_RD);
          end else begin
            tx_byte_d = NAK_BYTE;
            err_event = 1'b1;
          end
        end
      GET_ADDR:
        if (rx_error)         err_event  = 1'b1;
        else if (rx_received) bus_addr_d = rx_byte;
        else if (cnt_hit)     err_event  = 1'b1;
      GET_DATA:
        if (rx_error)         err_event   = 1'b1;
        else if (rx_received) bus_wdata_d = rx_byte;
        else if (cnt_hit)     err_event   = 1'b1;
      BUS_WR: begin
        bus_we_d  = 1'b1;
        tx_byte_d = ACK_BYTE;
        err_event = rx_stray;
      end
      BUS_RD: begin
        bus_re_d  = 1'b1;
        err_event = rx_stray;
      end
      WAIT_RD: begin
        if (rd_ok)        tx_byte_d = bus_rdata;
        else if (cnt_hit) tx_byte_d = NAK_BYTE;
        err_event = rx_stray || (!rd_ok && cnt_hit);
      end
      SEND: begin
        tx_transmit_d = !tx_busy;
        err_event     = rx_stray;
      end
      WAIT_TX_START: err_event = rx_stray || (!tx_busy && cnt_hit);
      WAIT_TX_END:   err_event = rx_stray;
      default: ;
    endcase

    // Any state change restarts the timeout; only the waiting states count.
    cnt_d = '0;
    if (state_d == state &&
        (state == GET_ADDR || state == GET_DATA || state == WAIT_RD || state == WAIT_TX_START))
      cnt_d = cnt + CW'(1);

    err_count_d = (err_event && err_count != '1) ? err_count + 8'd1 : err_count;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      is_rd       <= 1'b0;
      tx_transmit <= 1'b0;
      tx_byte     <= '0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_we      <= 1'b0;
      bus_re      <= 1'b0;
      err_count   <= '0;
      busy        <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      is_rd       <= is_rd_d;
      tx_transmit <= tx_transmit_d;
      tx_byte     <= tx_byte_d;
      bus_addr    <= bus_addr_d;
      bus_wdata   <= bus_wdata_d;
      bus_we      <= bus_we_d;
      bus_re      <= bus_re_d;
      err_count   <= err_count_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
module tb_uart_cmd_bridge;
  localparam int unsigned TO = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_received, rx_error, tx_busy, bus_rvalid;
  logic [7:0] rx_byte, bus_rdata;
  logic       tx_transmit, bus_we, bus_re, busy;
  logic [7:0] tx_byte, bus_addr, bus_wdata, err_count;

  uart_cmd_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_received(rx_received), .rx_byte(rx_byte), .rx_error(rx_error),
    .tx_transmit(tx_transmit), .tx_byte(tx_byte), .tx_busy(tx_busy),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard entries: {kind, addr, data}; kind 0 = write, 1 = read, 2 = reply
  logic [17:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_err = 0;
  logic [7:0]  bus_mem[256];
  logic [7:0]  model_mem[256];
  bit          uart_mute = 1'b0;
  bit          bus_mute  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_check(input string name, input logic [17:0] act);
    logic [17:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected output %0h, nothing expected (t=%0t)", name, act, $time);
    end else begin
      e = sb.pop_front();
      chk(name, {14'd0, act}, {14'd0, e});
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_we || bus_re) chk("we_re_exclusive", {31'd0, bus_we & bus_re}, 32'd0);
      if (bus_we) sb_check("bus_write", {2'd0, bus_addr, bus_wdata});
      if (bus_re) sb_check("bus_read", {2'd1, bus_addr, 8'h00});
      if (tx_transmit) begin
        chk("tx_while_busy", {31'd0, tx_busy}, 32'd0);
        sb_check("reply", {2'd2, 8'h00, tx_byte});
      end
    end
  end

  // Register-file model: answers once with garbage alongside bus_re (must be
  // ignored), then with real data 5 cycles later unless muted.
  initial begin
    logic [7:0] a;
    bus_rvalid = 1'b0;
    bus_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus_we) bus_mem[bus_addr] = bus_wdata;
      if (bus_re) begin
        a = bus_addr;
        bus_rvalid = 1'b1;
        bus_rdata  = ~bus_mem[a];
        @(negedge clk);
        bus_rvalid = 1'b0;
        if (!bus_mute) begin
          repeat (4) @(negedge clk);
          bus_rdata  = bus_mem[a];
          bus_rvalid = 1'b1;
          @(negedge clk);
          bus_rvalid = 1'b0;
        end
        bus_rdata = 8'($urandom);
      end
    end
  end

  // UART transmitter model
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_transmit && !uart_mute) begin
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        tx_busy = 1'b1;
        repeat ($urandom_range(3, 10)) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  task automatic inc_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte     = b;
    rx_received = 1'b1;
    @(negedge clk);
    rx_received = 1'b0;
    rx_byte     = 8'($urandom);
  endtask

  task automatic pulse_err(input bit with_rx);
    @(negedge clk);
    rx_error    = 1'b1;
    rx_received = with_rx;
    rx_byte     = 8'($urandom);
    @(negedge clk);
    rx_error    = 1'b0;
    rx_received = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err_count"}, {24'd0, err_count}, exp_err);
    chk({tag, "_all_outputs_seen"}, sb.size(), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tx_transmit"}, {31'd0, tx_transmit}, 32'd0);
    chk({tag, "_tx_byte"},     {24'd0, tx_byte},     32'd0);
    chk({tag, "_bus_addr"},    {24'd0, bus_addr},    32'd0);
    chk({tag, "_bus_wdata"},   {24'd0, bus_wdata},   32'd0);
    chk({tag, "_bus_we"},      {31'd0, bus_we},      32'd0);
    chk({tag, "_bus_re"},      {31'd0, bus_re},      32'd0);
    chk({tag, "_err_count"},   {24'd0, err_count},   32'd0);
    chk({tag, "_busy"},        {31'd0, busy},        32'd0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gmax, input int inject);
    sb.push_back({2'd0, a, d});
    sb.push_back({2'd2, 8'h00, 8'h4B});
    model_mem[a] = d;
    send_byte(8'h57); gap($urandom_range(0, gmax));
    send_byte(a);     gap($urandom_range(0, gmax));
    send_byte(d);
    if (inject != 0) begin
      for (int i = 0; i < 200; i++) begin
        if (tx_busy) break;
        @(negedge clk);
      end
      chk("tx_busy_seen", {31'd0, tx_busy}, 32'd1);
      if (inject == 1) send_byte(8'($urandom));
      else             pulse_err(inject == 3);
      inc_err();
    end
    wait_idle("write");
  endtask

  task automatic do_read(input logic [7:0] a, input int gmax);
    sb.push_back({2'd1, a, 8'h00});
    if (bus_mute) begin
      sb.push_back({2'd2, 8'h00, 8'h3F});
      inc_err();
    end else begin
      sb.push_back({2'd2, 8'h00, model_mem[a]});
    end
    send_byte(8'h52); gap($urandom_range(0, gmax));
    send_byte(a);
    wait_idle("read");
  endtask

  task automatic do_unknown(input logic [7:0] op);
    sb.push_back({2'd2, 8'h00, 8'h3F});
    inc_err();
    if (uart_mute) inc_err();
    send_byte(op);
    wait_idle("unknown");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    int         k;
    for (int i = 0; i < 256; i++) begin
      bus_mem[i]   = 8'(i * 37 + 11);
      model_mem[i] = 8'(i * 37 + 11);
    end
    bus_mem[8'h22]   = 8'h3C;
    model_mem[8'h22] = 8'h3C;
    rst = 1'b1; rx_received = 1'b0; rx_error = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    gap(2);

    do_write(8'h10, 8'hA5, 20, 0);
    do_read(8'h22, 5);
    bus_mute = 1'b1; do_read(8'h22, 5); bus_mute = 1'b0;
    do_unknown(8'h41);

    // abort by framing error, then a normal read
    send_byte(8'h57);
    pulse_err(1'b0); inc_err();
    wait_idle("abort");
    do_read(8'h00, 3);

    // error and byte in the same cycle during GET_DATA count once
    send_byte(8'h57); send_byte(8'h33);
    pulse_err(1'b1); inc_err();
    wait_idle("err_and_rx");

    // inter-byte timeout boundary
    send_byte(8'h52);
    gap(TO - 1);
    chk("ibto_still_waiting", {31'd0, busy}, 32'd1);
    gap(1);
    chk("ibto_expired", {31'd0, busy}, 32'd0);
    inc_err();
    wait_idle("ibto");

    do_write(8'h5C, 8'h7E, 4, 1);
    do_write(8'h5D, 8'h81, 4, 2);
    do_write(8'h5E, 8'h02, 4, 3);
    do_read(8'h5C, 2);

    uart_mute = 1'b1; do_unknown(8'h00); uart_mute = 1'b0;

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 5);
      case (k)
        0, 1: do_write(8'($urandom), 8'($urandom), 20, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0);
        2, 3: do_read(8'($urandom), 20);
        4: begin
          op = 8'($urandom);
          while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
          do_unknown(op);
        end
        default: begin bus_mute = 1'b1; do_read(8'($urandom), 20); bus_mute = 1'b0; end
      endcase
    end

    for (int n = 0; n < 260; n++) begin
      pulse_err(n[0]);
      inc_err();
    end
    wait_idle("saturate");
    chk("err_saturated", {24'd0, err_count}, 32'hFF);

    // asynchronous reset in GET_DATA
    send_byte(8'h57); send_byte(8'h99);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("async_reset");
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    sb.delete();
    gap(2);
    do_write(8'h44, 8'h55, 3, 0);
    do_read(8'h44, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
Byte-level command responder on the far side of the UART byte interface: consumes received bytes, decodes host read/write commands, and drives a simple register bus. Builds a one-byte reply per command and hands it to the UART transmit port with the transmit/is_transmitting handshake. It sits between the UART and the on-chip register file, and is the only UART-to-bus path.

Parameters:
TIMEOUT, 2500000, clock cycles allowed between command bytes, and for bus_rvalid after bus_re (100 ms at 25 MHz); minimum 2.
CMD_WR, 8'h57, write opcode 'W'.
CMD_RD, 8'h52, read opcode 'R'.
ACK_BYTE, 8'h4B, reply to a completed write 'K'.
NAK_BYTE, 8'h3F, reply to an unknown opcode or a read timeout '?'.

Ports:
clk  in  1  master clock
rst  in  1  reset, asynchronous, active-high
rx_received  in  1  one-cycle pulse; rx_byte is valid
rx_byte  in  8  received byte
rx_error  in  1  one-cycle UART framing-error pulse
tx_transmit  out  1  one-cycle request to send tx_byte
tx_byte  out  8  reply byte; held stable from tx_transmit until the reply completes
tx_busy  in  1  UART is_transmitting
bus_addr  out  8  register address
bus_wdata  out  8  write data
bus_we  out  1  one-cycle write strobe
bus_re  out  1  one-cycle read strobe
bus_rdata  in  8  read data; sampled when bus_rvalid=1
bus_rvalid  in  1  read data valid
err_count  out  8  saturating error counter
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, any state): state=IDLE; tx_transmit=0, tx_byte=0, bus_addr=0, bus_wdata=0, bus_we=0, bus_re=0, err_count=0, busy=0; timeout counter=0.
- All outputs are registered.
- States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, WAIT_RD, SEND, WAIT_TX_START, WAIT_TX_END.
- IDLE, on rx_received:
  - byte==CMD_WR or CMD_RD: latch the opcode, go to GET_ADDR.
  - any other byte: tx_byte=NAK_BYTE, err_count++, go to SEND.
- GET_ADDR, on rx_received: latch bus_addr; WR goes to GET_DATA, RD goes to BUS_RD.
- GET_DATA, on rx_received: latch bus_wdata, go to BUS_WR.
- BUS_WR: bus_we=1 for exactly one cycle; tx_byte=ACK_BYTE; go to SEND.
- BUS_RD: bus_re=1 for exactly one cycle; clear the timeout counter; go to WAIT_RD.
- WAIT_RD:
  - bus_rvalid=1: tx_byte=bus_rdata, go to SEND. bus_rvalid in the same cycle as bus_re is ignored.
  - counter reaches TIMEOUT-1 first: tx_byte=NAK_BYTE, err_count++, go to SEND.
- SEND: tx_transmit=1 for exactly one cycle, issued only when tx_busy=0; otherwise wait in SEND. Then go to WAIT_TX_START.
- WAIT_TX_START: wait for tx_busy=1, then WAIT_TX_END. If tx_busy is not seen within TIMEOUT cycles, err_count++ and go to IDLE.
- WAIT_TX_END: wait for tx_busy=0, then IDLE. Next command is accepted the cycle after the return to IDLE.
- Inter-byte timeout: the counter clears on every accepted byte. In GET_ADDR/GET_DATA, reaching TIMEOUT-1 without rx_received means err_count++, return to IDLE, no reply, no bus access.
- rx_error in IDLE/GET_ADDR/GET_DATA: err_count++, abort to IDLE, no reply.
- rx_error in BUS_WR..WAIT_TX_END: err_count++; the command in flight completes unchanged.
- rx_received in BUS_WR..WAIT_TX_END: byte dropped, err_count++. No buffering.
- rx_error and rx_received in the same cycle: rx_error wins, counted once.
- err_count saturates at 8'hFF. Two error events in one cycle count once.
- bus_we and bus_re are never high simultaneously. bus_addr/bus_wdata hold their last values.

Test Plan:
- Write: bytes 57,10,A5 with gaps of 20 cycles -> bus_we one cycle with addr=10, wdata=A5 -> tx_transmit once with tx_byte=4B; busy low after tx_busy falls; err_count=0.
- Read: bytes 52,22; bus model returns rvalid 5 cycles after bus_re with rdata=3C -> bus_re one cycle, addr=22 -> reply byte 3C.
- Read timeout (TIMEOUT=50): bytes 52,22 with no bus_rvalid -> after 50 cycles reply 3F, err_count=1.
- Unknown opcode 41 -> reply 3F, err_count=1, no bus strobe.
- Abort: byte 57 then rx_error pulse -> IDLE, no reply, err_count=1; a following 52,00 read completes normally.
- Drop and reset: rx_received during WAIT_TX_END -> err_count increments, reply unaffected. Then assert rst mid-GET_DATA -> all outputs 0 immediately, without waiting for a clock edge.
